// File: rtl/bf_sched.sv
// Butterfly scheduler for an in-place radix-2 transform of N = 2^LOGN points.
// Issues N/2 operand-pair reads per stage, tracks them through a
// RD_LAT+PE_LAT deep valid/address pipeline, and emits the matching
// write-backs. The next stage starts only after the last write-back of the
// current one, so reads never overtake pending writes.
// Optional feature: define BF_SCHED_CYCLE_CNT_EN to build the transform
// cycle counter on cyc_cnt; otherwise cyc_cnt is tied to zero.
module bf_sched #(
   parameter int LOGN   = 8,
   parameter int RD_LAT = 1,
   parameter int PE_LAT = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      rd_en,
   output logic [LOGN-1:0]           rd_addr_u,
   output logic [LOGN-1:0]           rd_addr_v,
   output logic [LOGN-2:0]           tw_idx,
   output logic                      wr_en,
   output logic [LOGN-1:0]           wr_addr_u,
   output logic [LOGN-1:0]           wr_addr_v,
   output logic [$clog2(LOGN)-1:0]   stage,
   output logic [31:0]               cyc_cnt
);

   localparam int SW = $clog2(LOGN);
   localparam int JW = LOGN - 1;
   localparam int D  = RD_LAT + PE_LAT;
   // all pipeline slots except the output slot
   localparam logic [D-1:0] PEND_MASK = {D{1'b1}} >> 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic [JW-1:0]   j_q, j_d;
   logic [SW-1:0]   stage_q, stage_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            rd_en_q, rd_en_d;
   logic [LOGN-1:0] rd_u_q, rd_u_d;
   logic [LOGN-1:0] rd_v_q, rd_v_d;
   logic [JW-1:0]   tw_q, tw_d;

   logic [D-1:0]    pv_q;
   logic [LOGN-1:0] pu_q [D];
   logic [LOGN-1:0] pw_q [D];
   logic            last_wr;

   // u operand address: group base (grp*2*span) plus offset inside the group
   function automatic logic [LOGN-1:0] addr_u(input logic [JW-1:0] j,
                                              input logic [SW-1:0] s);
      logic [LOGN-1:0] jx;
      logic [LOGN-1:0] mask;
      jx   = {1'b0, j};
      mask = (LOGN'(1) << s) - LOGN'(1);
      // two shifts instead of one by s+1: s+1 can overflow the SW-bit stage
      return (((jx >> s) << 1) << s) | (jx & mask);
   endfunction

   function automatic logic [JW-1:0] twiddle(input logic [JW-1:0] j,
                                             input logic [SW-1:0] s);
      logic [LOGN-1:0] jx;
      logic [LOGN-1:0] off;
      jx  = {1'b0, j};
      off = jx & ((LOGN'(1) << s) - LOGN'(1));
      return JW'(off << (SW'(LOGN - 1) - s));
   endfunction

   // stage finished: write-back slot valid and nothing else in flight
   always_comb begin
      last_wr = pv_q[D-1] & ~(|(pv_q & PEND_MASK)) & ~rd_en_q;
   end

   // next-state, counters and registered-output preparation
   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      stage_d = stage_q;
      rd_u_d  = rd_u_q;
      rd_v_d  = rd_v_q;
      tw_d    = tw_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               j_d     = '0;
               stage_d = '0;
            end
         end
         ISSUE: begin
            if (&j_q) begin
               state_d = DRAIN;
            end else begin
               j_d = j_q + JW'(1);
            end
         end
         DRAIN: begin
            if (last_wr) begin
               if (stage_q == SW'(LOGN - 1)) begin
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
                  j_d     = '0;
                  stage_d = stage_q + SW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      rd_en_d = (state_d == ISSUE);
      busy_d  = (state_d == ISSUE) || (state_d == DRAIN);
      done_d  = (state_d == DONE);
      if (rd_en_d) begin
         rd_u_d = addr_u(j_d, stage_d);
         rd_v_d = addr_u(j_d, stage_d) | (LOGN'(1) << stage_d);
         tw_d   = twiddle(j_d, stage_d);
      end
   end

   // control state and read-side output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         j_q     <= '0;
         stage_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
         rd_u_q  <= '0;
         rd_v_q  <= '0;
         tw_q    <= '0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         stage_q <= stage_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_en_q <= rd_en_d;
         rd_u_q  <= rd_u_d;
         rd_v_q  <= rd_v_d;
         tw_q    <= tw_d;
      end
   end

   // read-to-write-back delay line; held read addresses flow through, so the
   // write addresses also hold while no write is valid
   always_ff @(posedge clk) begin
      if (!rst) begin
         pv_q <= '0;
         for (int unsigned k = 0; k < D; k++) begin
            pu_q[k] <= '0;
            pw_q[k] <= '0;
         end
      end else begin
         pv_q[0] <= rd_en_q;
         pu_q[0] <= rd_u_q;
         pw_q[0] <= rd_v_q;
         for (int unsigned k = 1; k < D; k++) begin
            pv_q[k] <= pv_q[k-1];
            pu_q[k] <= pu_q[k-1];
            pw_q[k] <= pw_q[k-1];
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_en     = rd_en_q;
   assign rd_addr_u = rd_u_q;
   assign rd_addr_v = rd_v_q;
   assign tw_idx    = tw_q;
   assign wr_en     = pv_q[D-1];
   assign wr_addr_u = pu_q[D-1];
   assign wr_addr_v = pw_q[D-1];
   assign stage     = stage_q;

`ifdef BF_SCHED_CYCLE_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   // cleared by an accepted start, counts busy cycles, holds afterwards
   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == IDLE) && start) begin
         cnt_d = '0;
      end else if (busy_q) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // cycle counter register
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cyc_cnt = cnt_q;
`else
   assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_bf_sched.sv
// Scoreboard bench for bf_sched: small LOGN=3 instance with hand-computed
// read/write/done events, plus a default LOGN=8 instance checked by coverage.
module tb_bf_sched;

   logic clk;
   int   tcyc;
   int   n_vec;
   int   n_err;

   // LOGN=3 instance
   logic       rst_a, start_a, busy_a, done_a, rd_en_a, wr_en_a;
   logic [2:0] rd_addr_u_a, rd_addr_v_a, wr_addr_u_a, wr_addr_v_a;
   logic [1:0] tw_idx_a, stage_a;
   logic [31:0] cyc_cnt_a;

   // LOGN=8 instance
   logic       rst_b, start_b, busy_b, done_b, rd_en_b, wr_en_b;
   logic [7:0] rd_addr_u_b, rd_addr_v_b, wr_addr_u_b, wr_addr_v_b;
   logic [6:0] tw_idx_b;
   logic [2:0] stage_b;
   logic [31:0] cyc_cnt_b;

   bf_sched #(.LOGN(3), .RD_LAT(1), .PE_LAT(6)) u_a (
      .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
      .rd_en(rd_en_a), .rd_addr_u(rd_addr_u_a), .rd_addr_v(rd_addr_v_a),
      .tw_idx(tw_idx_a), .wr_en(wr_en_a), .wr_addr_u(wr_addr_u_a),
      .wr_addr_v(wr_addr_v_a), .stage(stage_a), .cyc_cnt(cyc_cnt_a)
   );

   bf_sched u_b (
      .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
      .rd_en(rd_en_b), .rd_addr_u(rd_addr_u_b), .rd_addr_v(rd_addr_v_b),
      .tw_idx(tw_idx_b), .wr_en(wr_en_b), .wr_addr_u(wr_addr_u_b),
      .wr_addr_v(wr_addr_v_b), .stage(stage_b), .cyc_cnt(cyc_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) tcyc <= tcyc + 1;

   typedef struct {
      int cyc;
      int u;
      int v;
      int tw;
      int st;
   } ev_t;

   ev_t rd_q [$];
   ev_t wr_q [$];
   int  done_q [$];
   int  base_a;
   int  base_b;

   // hand-derived LOGN=3 schedule (start sampled at the end of cycle 0)
   int exp_rc [12] = '{1, 2, 3, 4, 12, 13, 14, 15, 23, 24, 25, 26};
   int exp_u  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int exp_v  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input int rel);
      n_vec++;
      n_err++;
      $display("FAIL %s at cycle %0d: got an event, expected none", name, rel);
   endtask

   task automatic push_exp(input int nrd, input int nwr, input bit with_done);
      ev_t e;
      for (int i = 0; i < nrd; i++) begin
         e.cyc = exp_rc[i]; e.u = exp_u[i]; e.v = exp_v[i]; e.tw = exp_tw[i]; e.st = i / 4;
         rd_q.push_back(e);
      end
      for (int i = 0; i < nwr; i++) begin
         e.cyc = exp_rc[i] + 7; e.u = exp_u[i]; e.v = exp_v[i]; e.tw = 0; e.st = i / 4;
         wr_q.push_back(e);
      end
      if (with_done) done_q.push_back(34);
   endtask

   // monitor: pops expected events whenever the small instance presents one
   always @(negedge clk) begin
      int  rel;
      ev_t e;
      rel = tcyc - base_a;
      if (rd_en_a === 1'b1) begin
         if (rd_q.size() == 0) flag("rd_en_unexpected", rel);
         else begin
            e = rd_q.pop_front();
            chk("rd_cycle", rel, e.cyc);
            chk("rd_addr_u", rd_addr_u_a, e.u);
            chk("rd_addr_v", rd_addr_v_a, e.v);
            chk("tw_idx", tw_idx_a, e.tw);
            chk("rd_stage", stage_a, e.st);
         end
      end
      if (wr_en_a === 1'b1) begin
         if (wr_q.size() == 0) flag("wr_en_unexpected", rel);
         else begin
            e = wr_q.pop_front();
            chk("wr_cycle", rel, e.cyc);
            chk("wr_addr_u", wr_addr_u_a, e.u);
            chk("wr_addr_v", wr_addr_v_a, e.v);
            chk("wr_stage", stage_a, e.st);
         end
      end
      if (done_a === 1'b1) begin
         if (done_q.size() == 0) flag("done_unexpected", rel);
         else chk("done_cycle", rel, done_q.pop_front());
      end
   end

   // coverage monitor for the LOGN=8 instance
   int nrd_b, nwr_b, ndone_b, bad_b, done_rel_b;
   int wcnt [8][256];

   always @(negedge clk) begin
      if (rd_en_b === 1'b1) begin
         nrd_b++;
         if (int'(rd_addr_v_b) - int'(rd_addr_u_b) != (1 << stage_b)) bad_b++;
         if ((int'(tw_idx_b) & ((1 << (7 - int'(stage_b))) - 1)) != 0) bad_b++;
      end
      if (wr_en_b === 1'b1) begin
         nwr_b++;
         wcnt[stage_b][wr_addr_u_b]++;
         wcnt[stage_b][wr_addr_v_b]++;
         if (int'(wr_addr_v_b) - int'(wr_addr_u_b) != (1 << stage_b)) bad_b++;
      end
      if (done_b === 1'b1) begin
         ndone_b++;
         done_rel_b = tcyc - base_b;
      end
   end

   // mode 0: plain run, 1: start re-pulsed at cycle 10, 2: reset at cycle 15
   task automatic run_a(input int mode);
      bit aborted;
      int exp_cnt;
      if (mode == 2) push_exp(8, 4, 1'b0);
      else push_exp(12, 12, 1'b1);
      @(posedge clk); #1;
      start_a = 1'b1;
      base_a  = tcyc;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (mode == 1) start_a = (c == 10);
         if (mode == 2 && c == 15) rst_a = 1'b0;
         if (mode == 2 && c == 16) rst_a = 1'b1;
         aborted = (mode == 2) && (c >= 16);
         chk("busy", busy_a, (!aborted && c <= 33));
         if (aborted) begin
            chk("rd_en_after_reset", rd_en_a, 0);
            chk("wr_en_after_reset", wr_en_a, 0);
            chk("done_after_reset", done_a, 0);
         end
`ifdef BF_SCHED_CYCLE_CNT_EN
         exp_cnt = aborted ? 0 : ((c <= 34) ? c - 1 : 33);
`else
         exp_cnt = 0;
`endif
         chk("cyc_cnt", cyc_cnt_a, exp_cnt);
      end
      chk("rd_missing", rd_q.size(), 0);
      chk("wr_missing", wr_q.size(), 0);
      chk("done_missing", done_q.size(), 0);
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
   endtask

   task automatic run_b();
      int nbad;
      @(posedge clk); #1;
      start_b = 1'b1;
      base_b  = tcyc;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int c = 1; c <= 1200 && ndone_b == 0; c++) @(negedge clk);
      repeat (10) @(negedge clk);
      chk("n8_rd_count", nrd_b, 1024);
      chk("n8_wr_count", nwr_b, 1024);
      chk("n8_done_count", ndone_b, 1);
      chk("n8_done_cycle", done_rel_b, 1081);
      chk("n8_pair_shape", bad_b, 0);
      for (int s = 0; s < 8; s++) begin
         nbad = 0;
         for (int a = 0; a < 256; a++) if (wcnt[s][a] != 1) nbad++;
         chk("n8_stage_write_cover", nbad, 0);
      end
`ifdef BF_SCHED_CYCLE_CNT_EN
      chk("n8_cyc_cnt", cyc_cnt_b, 1080);
`else
      chk("n8_cyc_cnt", cyc_cnt_b, 0);
`endif
      chk("n8_busy_after", busy_b, 0);
   endtask

   initial begin
      n_vec = 0; n_err = 0; tcyc = 0; base_a = 0; base_b = 0;
      nrd_b = 0; nwr_b = 0; ndone_b = 0; bad_b = 0; done_rel_b = 0;
      rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_rd_en", rd_en_a, 0);
      chk("rst_wr_en", wr_en_a, 0);
      chk("rst_rd_addr_u", rd_addr_u_a, 0);
      chk("rst_rd_addr_v", rd_addr_v_a, 0);
      chk("rst_tw_idx", tw_idx_a, 0);
      chk("rst_wr_addr_u", wr_addr_u_a, 0);
      chk("rst_wr_addr_v", wr_addr_v_a, 0);
      chk("rst_stage", stage_a, 0);
      chk("rst_cyc_cnt", cyc_cnt_a, 0);
      chk("rst_busy_n8", busy_b, 0);
      @(posedge clk); #1;
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (2) @(posedge clk);
      run_a(0);
      run_a(1);
      run_a(2);
      run_a(0);
      run_b();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
